max7219_rx_emulator: RTL and testbench

//  Receive side of the MAX7219 serial link: emulates a daisy chain of NUM_CASCADES MAX7219 devices.

---
 rtl/max7219_pkg.sv | 26 ++
 rtl/max7219_rx_regs.sv | 50 +++++
 rtl/max7219_rx_emulator.sv | 100 ++++++++++
 tb/tb_max7219_rx_emulator.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/max7219_pkg.sv
// rtl/max7219_pkg.sv - shared constants and frame word type for the MAX7219 receive emulator
package max7219_pkg;

  localparam int FRAME_BITS = 16;

  localparam logic [3:0] REG_NOP          = 4'h0;
  localparam logic [3:0] REG_DIGIT0       = 4'h1;
  localparam logic [3:0] REG_DIGIT7       = 4'h8;
  localparam logic [3:0] REG_DECODE_MODE  = 4'h9;
  localparam logic [3:0] REG_INTENSITY    = 4'hA;
  localparam logic [3:0] REG_SCAN_LIMIT   = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN     = 4'hC;
  localparam logic [3:0] REG_DISPLAY_TEST = 4'hF;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } frame_word_t;

  function automatic logic [2:0] digit_index(input logic [3:0] reg_addr);
    logic [3:0] idx;
    idx = reg_addr - REG_DIGIT0;
    return idx[2:0];
  endfunction

endpackage

// File: rtl/max7219_rx_regs.sv
// rtl/max7219_rx_regs.sv - register file of one emulated device, written from a latched {addr,data} word
module max7219_rx_regs
  import max7219_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  latch_en,
  input  logic [FRAME_BITS-1:0] word,
  output logic [63:0]           digits,
  output logic [7:0]            decode_mode,
  output logic [3:0]            intensity,
  output logic [2:0]            scan_limit,
  output logic                  shutdown_n,
  output logic                  display_test
);

  frame_word_t w;
  logic [3:0]  reg_addr;
  logic        unused_addr_hi;

  assign w        = word;
  assign reg_addr = w.addr[3:0];
  // The real part ignores the upper address nibble, so it never takes part in decode.
  assign unused_addr_hi = ^w.addr[7:4];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      digits       <= '0;
      decode_mode  <= '0;
      intensity    <= '0;
      scan_limit   <= '0;
      shutdown_n   <= 1'b0;
      display_test <= 1'b0;
    end else if (latch_en) begin
      case (reg_addr)
        REG_NOP:          ;
        REG_DECODE_MODE:  decode_mode  <= w.data;
        REG_INTENSITY:    intensity    <= w.data[3:0];
        REG_SCAN_LIMIT:   scan_limit   <= w.data[2:0];
        REG_SHUTDOWN:     shutdown_n   <= w.data[0];
        REG_DISPLAY_TEST: display_test <= w.data[0];
        default: begin
          if (reg_addr >= REG_DIGIT0 && reg_addr <= REG_DIGIT7)
            digits[8*digit_index(reg_addr) +: 8] <= w.data;
        end
      endcase
    end
  end

endmodule

// File: rtl/max7219_rx_emulator.sv
// rtl/max7219_rx_emulator.sv - oversampling receiver emulating a daisy chain of MAX7219 devices
module max7219_rx_emulator
  import max7219_pkg::*;
#(
  parameter int NUM_CASCADES = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      spi_clk,
  input  logic                      din,
  input  logic                      cs,
  output logic                      dout,
  output logic [64*NUM_CASCADES-1:0] digit_regs,
  output logic [8*NUM_CASCADES-1:0] decode_mode,
  output logic [4*NUM_CASCADES-1:0] intensity,
  output logic [3*NUM_CASCADES-1:0] scan_limit,
  output logic [NUM_CASCADES-1:0]   shutdown_n,
  output logic [NUM_CASCADES-1:0]   display_test,
  output logic                      upd_stb,
  output logic                      frame_err
);

  localparam int SHIFT_W = FRAME_BITS * NUM_CASCADES;
  localparam int CNT_W   = $clog2(SHIFT_W + 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SHIFT_W);
  localparam logic [CNT_W-1:0] SAT_CNT  = CNT_W'(SHIFT_W + 1);

  // bit 0 = sync stage 1, bit 1 = stage 2, bit 2 = edge-detect history
  logic [2:0] sclk_sync;
  logic [2:0] cs_sync;
  logic [1:0] din_sync;

  logic [SHIFT_W-1:0] shift_q;
  logic [CNT_W-1:0]   cnt_q;

  logic sclk_rise;
  logic cs_fall;
  logic cs_rise;
  logic shift_en;
  logic latch_en;
  logic err_det;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sclk_sync <= '1;
      cs_sync   <= '1;
      din_sync  <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi_clk};
      cs_sync   <= {cs_sync[1:0], cs};
      din_sync  <= {din_sync[0], din};
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign cs_fall   = ~cs_sync[1] & cs_sync[2];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];
  // A clock edge coinciding with cs rise is dropped because synced cs is already high.
  assign shift_en  = sclk_rise & ~cs_sync[1];
  assign latch_en  = cs_rise & (cnt_q == FULL_CNT);
  assign err_det   = cs_rise & (cnt_q != '0) & (cnt_q != FULL_CNT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      dout      <= 1'b0;
      upd_stb   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      upd_stb   <= latch_en;
      frame_err <= err_det;
      if (shift_en) begin
        shift_q <= {shift_q[SHIFT_W-2:0], din_sync[1]};
        dout    <= shift_q[SHIFT_W-1];
      end
      if (cs_fall)
        cnt_q <= shift_en ? CNT_W'(1) : '0;
      else if (shift_en && cnt_q != SAT_CNT)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Word 0 is the most recently shifted word and belongs to the nearest device.
  for (genvar k = 0; k < NUM_CASCADES; k++) begin : g_dev
    max7219_rx_regs u_regs (
      .clk          (clk),
      .reset_n      (reset_n),
      .latch_en     (latch_en),
      .word         (shift_q[FRAME_BITS*k +: FRAME_BITS]),
      .digits       (digit_regs[64*k +: 64]),
      .decode_mode  (decode_mode[8*k +: 8]),
      .intensity    (intensity[4*k +: 4]),
      .scan_limit   (scan_limit[3*k +: 3]),
      .shutdown_n   (shutdown_n[k]),
      .display_test (display_test[k])
    );
  end

endmodule

// File: tb/tb_max7219_rx_emulator.sv
// tb/tb_max7219_rx_emulator.sv - randomized bench driving one- and two-device emulators from a shared link
module tb_max7219_rx_emulator;

  logic clk, reset_n, spi_clk, din, cs;

  logic         d1_dout, d1_upd, d1_err;
  logic [63:0]  d1_digit;
  logic [7:0]   d1_dec;
  logic [3:0]   d1_int;
  logic [2:0]   d1_scan;
  logic [0:0]   d1_shdn, d1_test;

  logic         d2_dout, d2_upd, d2_err;
  logic [127:0] d2_digit;
  logic [15:0]  d2_dec;
  logic [7:0]   d2_int;
  logic [5:0]   d2_scan;
  logic [1:0]   d2_shdn, d2_test;

  max7219_rx_emulator #(.NUM_CASCADES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .spi_clk(spi_clk), .din(din), .cs(cs),
    .dout(d1_dout), .digit_regs(d1_digit), .decode_mode(d1_dec), .intensity(d1_int),
    .scan_limit(d1_scan), .shutdown_n(d1_shdn), .display_test(d1_test),
    .upd_stb(d1_upd), .frame_err(d1_err)
  );

  max7219_rx_emulator #(.NUM_CASCADES(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .spi_clk(spi_clk), .din(din), .cs(cs),
    .dout(d2_dout), .digit_regs(d2_digit), .decode_mode(d2_dec), .intensity(d2_int),
    .scan_limit(d2_scan), .shutdown_n(d2_shdn), .display_test(d2_test),
    .upd_stb(d2_upd), .frame_err(d2_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: per-instance register files (inst 0 = one device, inst 1 = two devices)
  logic [7:0] m_digit [2][2][8];
  logic [7:0] m_dec   [2][2];
  logic [3:0] m_int   [2][2];
  logic [2:0] m_scan  [2][2];
  logic       m_shdn  [2][2];
  logic       m_test  [2][2];
  bit         hist[$];
  bit         frame_q[$];
  bit         tx[$];
  bit         exp_upd [2];
  bit         exp_err [2];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 2; k++) begin
        for (int d = 0; d < 8; d++) m_digit[i][k][d] = 8'h00;
        m_dec[i][k]  = 8'h00;
        m_int[i][k]  = 4'h0;
        m_scan[i][k] = 3'h0;
        m_shdn[i][k] = 1'b0;
        m_test[i][k] = 1'b0;
      end
    hist.delete();
    frame_q.delete();
  endfunction

  function automatic void model_apply(int inst, int dev, logic [15:0] w);
    int a;
    a = int'(w[11:8]);
    if (a >= 1 && a <= 8) m_digit[inst][dev][a-1] = w[7:0];
    else if (a == 9)  m_dec[inst][dev]  = w[7:0];
    else if (a == 10) m_int[inst][dev]  = w[3:0];
    else if (a == 11) m_scan[inst][dev] = w[2:0];
    else if (a == 12) m_shdn[inst][dev] = w[0];
    else if (a == 15) m_test[inst][dev] = w[0];
  endfunction

  // Frame accepted only with exactly 16 bits per device; the last 16 bits go to device 0.
  function automatic void model_cs_rise();
    int cnt;
    logic [15:0] w;
    cnt = frame_q.size();
    for (int i = 0; i < 2; i++) begin
      exp_upd[i] = (cnt == 16*(i+1));
      exp_err[i] = (cnt != 0) && (cnt != 16*(i+1));
      if (exp_upd[i])
        for (int k = 0; k <= i; k++) begin
          for (int j = 0; j < 16; j++) w[j] = frame_q[cnt-1-(16*k+j)];
          model_apply(i, k, w);
        end
    end
  endfunction

  task automatic check_regs(input int inst);
    logic [127:0] ed;
    logic [15:0]  edec;
    logic [7:0]   eint;
    logic [5:0]   escan;
    logic [1:0]   eshd, etst;
    ed = '0; edec = '0; eint = '0; escan = '0; eshd = '0; etst = '0;
    for (int k = 0; k <= inst; k++) begin
      for (int d = 0; d < 8; d++) ed[64*k+8*d +: 8] = m_digit[inst][k][d];
      edec[8*k +: 8]  = m_dec[inst][k];
      eint[4*k +: 4]  = m_int[inst][k];
      escan[3*k +: 3] = m_scan[inst][k];
      eshd[k]         = m_shdn[inst][k];
      etst[k]         = m_test[inst][k];
    end
    if (inst == 0) begin
      check("n1_digits", d1_digit, ed);
      check("n1_decode", d1_dec, edec);
      check("n1_intensity", d1_int, eint);
      check("n1_scan", d1_scan, escan);
      check("n1_shutdown_n", d1_shdn, eshd);
      check("n1_test", d1_test, etst);
    end else begin
      check("n2_digits", d2_digit, ed);
      check("n2_decode", d2_dec, edec);
      check("n2_intensity", d2_int, eint);
      check("n2_scan", d2_scan, escan);
      check("n2_shutdown_n", d2_shdn, eshd);
      check("n2_test", d2_test, etst);
    end
  endtask

  // dout is the serial stream delayed by 16 bits per device
  task automatic send_bit(input bit b);
    int idx;
    din = b;
    repeat (4) @(negedge clk);
    spi_clk = 1'b1;
    frame_q.push_back(b);
    hist.push_back(b);
    repeat (4) @(negedge clk);
    spi_clk = 1'b0;
    repeat (4) @(negedge clk);
    idx = hist.size() - 1;
    check("dout_n1", d1_dout, (idx >= 16) ? hist[idx-16] : 1'b0);
    check("dout_n2", d2_dout, (idx >= 32) ? hist[idx-32] : 1'b0);
  endtask

  task automatic start_frame();
    cs = 1'b0;
    frame_q.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic end_frame();
    repeat (2) @(negedge clk);
    cs = 1'b1;
    model_cs_rise();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("upd_n1", d1_upd, (c == 3) ? exp_upd[0] : 1'b0);
      check("err_n1", d1_err, (c == 3) ? exp_err[0] : 1'b0);
      check("upd_n2", d2_upd, (c == 3) ? exp_upd[1] : 1'b0);
      check("err_n2", d2_err, (c == 3) ? exp_err[1] : 1'b0);
    end
    check_regs(0);
    check_regs(1);
    repeat (2) @(negedge clk);
  endtask

  task automatic add_word(input logic [15:0] w);
    for (int j = 15; j >= 0; j--) tx.push_back(w[j]);
  endtask

  task automatic run_frame();
    start_frame();
    foreach (tx[i]) send_bit(tx[i]);
    end_frame();
    tx.delete();
  endtask

  initial begin
    int r, nbits;
    logic [15:0] w;
    reset_n = 1'b0; cs = 1'b1; spi_clk = 1'b0; din = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_dout_n1", d1_dout, 1'b0);
    check("reset_dout_n2", d2_dout, 1'b0);
    check("reset_upd_n1", d1_upd, 1'b0);
    check("reset_err_n2", d2_err, 1'b0);
    check_regs(0);
    check_regs(1);

    add_word(16'h0C01); run_frame();
    add_word(16'h0355); run_frame();
    add_word(16'h0A1F); run_frame();
    add_word(16'h0A07); add_word(16'h0B03); run_frame();
    for (int i = 0; i < 12; i++) tx.push_back(1'($urandom_range(0, 1)));
    run_frame();
    for (int i = 0; i < 17; i++) tx.push_back(1'($urandom_range(0, 1)));
    run_frame();
    run_frame();

    // reset in the middle of a frame; the remainder is counted from zero
    start_frame();
    for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));
    end_frame();

    add_word(16'h00AA); add_word(16'h0F01); run_frame();
    add_word(16'h00AA); run_frame();
    add_word(16'h0F01); run_frame();

    for (int f = 0; f < 40; f++) begin
      r = $urandom_range(0, 9);
      if (r < 8) begin
        for (int k = 0; k < ((r < 4) ? 1 : (r < 7) ? 2 : 3); k++) begin
          w[15:12] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
          w[11:8]  = 4'($urandom_range(0, 15));
          w[7:0]   = 8'($urandom);
          add_word(w);
        end
      end else begin
        nbits = $urandom_range(0, 40);
        for (int i = 0; i < nbits; i++) tx.push_back(1'($urandom_range(0, 1)));
      end
      run_frame();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
